// File: rtl/fetch_align_stage.sv
// fetch_align_stage: fetches words from imem, splits them into halfwords and issues one RVC/32-bit instruction per cycle
module fetch_align_stage #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          QDEPTH   = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rerror,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_exception,
    output logic [3:0]  f_ecause,
    output logic [31:0] f_etval
);
    localparam int HW = 2 * QDEPTH;
    localparam int PW = $clog2(HW);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    // Each queue entry is {error tag, halfword}
    logic [16:0]   q_mem [HW];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_q, out_d, drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, dec_pc_q, dec_pc_d;
    logic          skip_q, skip_d, lock_q, lock_d;
    logic          f_valid_q, f_valid_d, f_exc_q, f_exc_d;
    logic [31:0]   f_pc_q, f_pc_d, f_instr_q, f_instr_d;

    logic          req_fire, push, iss_v, iss_exc;
    logic [1:0]    in_n, pop_n;
    logic [16:0]   in_lo, in_hi, h0, h1;
    logic [31:0]   avail, qwords, iss_instr;

    // Request credit: never more halfwords in flight than the queue can absorb
    always_comb begin
        qwords     = (32'(cnt_q) + 32'd1) >> 1;
        imem_valid = !lock_q && !redirect && (32'(out_q) < 32'(MAX_OUT))
                     && (qwords + 32'(out_q) < 32'(QDEPTH));
        imem_addr  = {fetch_pc_q[31:2], 2'b00};
        req_fire   = imem_valid && imem_ready;
    end

    // Incoming halfwords are visible to the issue logic in the cycle they arrive (bypass)
    always_comb begin
        push  = imem_rvalid && (drop_q == '0) && !redirect;
        in_lo = {imem_rerror, skip_q ? imem_rdata[31:16] : imem_rdata[15:0]};
        in_hi = {imem_rerror, imem_rdata[31:16]};
        in_n  = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        avail = 32'(cnt_q) + 32'(in_n);
        h0    = (cnt_q != '0) ? q_mem[rd_q] : in_lo;
        h1    = (32'(cnt_q) >= 32'd2) ? q_mem[rd_q + 1'b1] : ((cnt_q == CW'(1)) ? in_lo : in_hi);
    end

    // Issue decision: RVC takes one halfword, 32-bit takes two, a faulted halfword issues as an exception
    always_comb begin
        iss_v     = 1'b0;
        iss_exc   = 1'b0;
        iss_instr = 32'h0;
        pop_n     = 2'd0;
        if (!stall && !redirect && !lock_q && avail != 32'd0) begin
            if (h0[16]) begin
                iss_v   = 1'b1;
                iss_exc = 1'b1;
                pop_n   = 2'd1;
            end else if (h0[1:0] != 2'b11) begin
                iss_v     = 1'b1;
                iss_instr = {16'h0, h0[15:0]};
                pop_n     = 2'd1;
            end else if (avail >= 32'd2) begin
                iss_v     = 1'b1;
                iss_exc   = h1[16];
                iss_instr = h1[16] ? 32'h0 : {h1[15:0], h0[15:0]};
                pop_n     = 2'd2;
            end
        end
    end

    // Next-state: redirect wins over everything, otherwise push/pop/request bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        dec_pc_d   = dec_pc_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        out_d      = out_q + OW'(req_fire) - OW'(imem_rvalid);
        drop_d     = drop_q;
        skip_d     = skip_q;
        lock_d     = lock_q;
        f_valid_d  = f_valid_q;
        f_pc_d     = f_pc_q;
        f_instr_d  = f_instr_q;
        f_exc_d    = f_exc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            dec_pc_d   = redirect_pc;
            wr_d       = '0;
            rd_d       = '0;
            cnt_d      = '0;
            drop_d     = out_q - OW'(imem_rvalid);
            skip_d     = redirect_pc[1];
            lock_d     = 1'b0;
            f_valid_d  = 1'b0;
            f_pc_d     = 32'h0;
            f_instr_d  = 32'h0;
            f_exc_d    = 1'b0;
        end else begin
            fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
            drop_d     = (imem_rvalid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
            skip_d     = push ? 1'b0 : skip_q;
            wr_d       = wr_q + PW'(in_n);
            rd_d       = rd_q + PW'(pop_n);
            cnt_d      = cnt_q + CW'(in_n) - CW'(pop_n);
            dec_pc_d   = dec_pc_q + {29'd0, pop_n, 1'b0};
            lock_d     = lock_q || iss_exc;
            if (!stall) begin
                f_valid_d = iss_v;
                f_pc_d    = iss_v ? dec_pc_q : 32'h0;
                f_instr_d = iss_instr;
                f_exc_d   = iss_exc;
            end
        end
    end

    // Halfword storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_q] <= in_lo;
            if (!skip_q) q_mem[wr_q + 1'b1] <= in_hi;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            dec_pc_q   <= RESET_PC;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            skip_q     <= 1'b0;
            lock_q     <= 1'b0;
            f_valid_q  <= 1'b0;
            f_pc_q     <= 32'h0;
            f_instr_q  <= 32'h0;
            f_exc_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            dec_pc_q   <= dec_pc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            skip_q     <= skip_d;
            lock_q     <= lock_d;
            f_valid_q  <= f_valid_d;
            f_pc_q     <= f_pc_d;
            f_instr_q  <= f_instr_d;
            f_exc_q    <= f_exc_d;
        end
    end

    assign f_valid     = f_valid_q;
    assign f_pc        = f_pc_q;
    assign f_instr     = f_instr_q;
    assign f_exception = f_exc_q;
    assign f_ecause    = f_exc_q ? 4'd1 : 4'd0;
    assign f_etval     = f_exc_q ? f_pc_q : 32'h0;
endmodule

// File: tb/tb_fetch_align_stage.sv
// tb_fetch_align_stage: cycle-by-cycle directed vectors for the fetch/align stage
module tb_fetch_align_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid, imem_ready, imem_rvalid, imem_rerror;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic        redirect, stall;
    logic        f_valid, f_exception;
    logic [31:0] f_pc, f_instr, f_etval;
    logic [3:0]  f_ecause;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        rerr, redir;
        logic [31:0] rpc;
        logic        stl;
        logic        e_iv;
        logic [31:0] e_ia;
        logic        e_fv;
        logic [31:0] e_pc, e_in;
        logic        e_exc;
    } vec_t;

    vec_t tv[$];

    fetch_align_stage dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rerror(imem_rerror),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_exception(f_exception),
        .f_ecause(f_ecause), .f_etval(f_etval)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic rerr, logic redir,
                                logic [31:0] rpc, logic stl, logic iv, logic [31:0] ia, logic fv,
                                logic [31:0] pc, logic [31:0] ins, logic exc);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rdata = rdata; r.rerr = rerr; r.redir = redir; r.rpc = rpc;
        r.stl = stl; r.e_iv = iv; r.e_ia = ia; r.e_fv = fv; r.e_pc = pc; r.e_in = ins; r.e_exc = exc;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rdy, logic rv, logic [31:0] rdata, logic rerr, logic redir,
                         logic [31:0] rpc, logic stl);
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata; imem_rerror = rerr;
        redirect = redir; redirect_pc = rpc; stall = stl;
    endtask

    task automatic chk_f(string nm, logic fv, logic [31:0] pc, logic [31:0] ins, logic exc);
        n_vec++;
        chk({nm, " f_valid"}, 32'(f_valid), 32'(fv));
        if (fv) begin
            chk({nm, " f_pc"}, f_pc, pc);
            chk({nm, " f_instr"}, f_instr, ins);
            chk({nm, " f_exception"}, 32'(f_exception), 32'(exc));
            if (exc) begin
                chk({nm, " f_ecause"}, 32'(f_ecause), 32'd1);
                chk({nm, " f_etval"}, f_etval, pc);
            end
        end
    endtask

    initial begin
        // Sequential fetch, 32-bit 0x13 words
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h0,  0,32'h0,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h13,0,0,32'h0,0, 1,32'h4, 1,32'h0,32'h13,0));
        tv.push_back(mk(1,1'b1,32'h13,0,0,32'h0,0, 1,32'h8, 1,32'h4,32'h13,0));
        tv.push_back(mk(1,1'b1,32'h13,0,0,32'h0,0, 1,32'hC, 1,32'h8,32'h13,0));
        // Two outstanding, then redirect to 0x102
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h10, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b0,32'h0,0,1,32'h102,0, 0,32'h0, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'h13,0,0,32'h0,0, 0,32'h0, 0,32'h0,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h13,0,0,32'h0,0, 1,32'h100, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'h00014505,0,0,32'h0,0, 1,32'h104, 1,32'h102,32'h1,0));
        // 32-bit instruction straddling two words
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h104, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'h00134501,0,0,32'h0,0, 1,32'h108, 1,32'h104,32'h4501,0));
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h108, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'h0,0,0,32'h0,0, 1,32'h10C, 1,32'h106,32'h13,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 1,32'h10C, 1,32'h10A,32'h0,0));
        // Stall while the queue fills
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,1, 1,32'h10C, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h00100013,0,0,32'h0,1, 1,32'h110, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h00200013,0,0,32'h0,1, 1,32'h114, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h00300013,0,0,32'h0,1, 1,32'h118, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b1,32'h00400013,0,0,32'h0,1, 0,32'h0, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,1, 0,32'h0, 1,32'h10A,32'h0,0));
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,1, 0,32'h0, 1,32'h10A,32'h0,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 0,32'h0, 1,32'h10C,32'h00100013,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 1,32'h11C, 1,32'h110,32'h00200013,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 1,32'h11C, 1,32'h114,32'h00300013,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 1,32'h11C, 1,32'h118,32'h00400013,0));
        // Access fault, lock until redirect
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h11C, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'hDEADBEEF,1,0,32'h0,0, 1,32'h120, 1,32'h11C,32'h0,1));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 0,32'h0, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b0,32'h0,0,1,32'h200,0, 0,32'h0, 0,32'h0,32'h0,0));
        tv.push_back(mk(1,1'b0,32'h0,0,0,32'h0,0, 1,32'h200, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b1,32'h13,0,0,32'h0,0, 1,32'h204, 1,32'h200,32'h13,0));
        // Redirect beats stall
        tv.push_back(mk(0,1'b0,32'h0,0,1,32'h400,1, 0,32'h0, 0,32'h0,32'h0,0));
        tv.push_back(mk(0,1'b0,32'h0,0,0,32'h0,0, 1,32'h400, 0,32'h0,32'h0,0));

        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) @(negedge clock);
        n_vec++;
        chk("reset f_valid", 32'(f_valid), 32'd0);
        chk("reset f_pc", f_pc, 32'h0);
        chk("reset f_instr", f_instr, 32'h0);
        chk("reset f_exception", 32'(f_exception), 32'd0);
        chk("reset imem_valid", 32'(imem_valid), 32'd1);
        chk("reset imem_addr", imem_addr, 32'h0);
        reset = 1'b1;

        foreach (tv[i]) begin
            @(negedge clock);
            drive(tv[i].rdy, tv[i].rv, tv[i].rdata, tv[i].rerr, tv[i].redir, tv[i].rpc, tv[i].stl);
            #1;
            chk($sformatf("v%0d imem_valid", i), 32'(imem_valid), 32'(tv[i].e_iv));
            if (tv[i].e_iv) chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].e_ia);
            @(posedge clock);
            #1;
            chk_f($sformatf("v%0d", i), tv[i].e_fv, tv[i].e_pc, tv[i].e_in, tv[i].e_exc);
        end

        // Mid-transaction asynchronous reset
        @(negedge clock);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clock);
        drive(0, 1, 32'h13, 0, 0, 32'h0, 0);
        @(posedge clock);
        #1;
        chk_f("pre-reset", 1'b1, 32'h400, 32'h13, 1'b0);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        reset = 1'b0;
        #1;
        n_vec++;
        chk("async reset f_valid", 32'(f_valid), 32'd0);
        chk("async reset imem_addr", imem_addr, 32'h0);
        chk("async reset imem_valid", 32'(imem_valid), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Two RVC instructions from one word after reset
        @(negedge clock);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clock);
        drive(0, 1, 32'h00014505, 0, 0, 32'h0, 0);
        @(posedge clock);
        #1;
        chk_f("rvc lo", 1'b1, 32'h0, 32'h4505, 1'b0);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(posedge clock);
        #1;
        chk_f("rvc hi", 1'b1, 32'h2, 32'h1, 1'b0);
        @(posedge clock);
        #1;
        chk_f("rvc drained", 1'b0, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
